// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake stream checker.
package hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] BP_ALWAYS = 2'd0;
  localparam logic [1:0] BP_LFSR   = 2'd1;
  localparam logic [1:0] BP_DUTY   = 2'd2;
  localparam logic [1:0] BP_NEVER  = 2'd3;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/hs_bp_gen.sv
// Backpressure generator: registered ready from an LFSR, a duty counter or a
// constant, selected by bp_mode; ready is only ever high while the checker runs.
module hs_bp_gen
  import hs_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic       i_run_next,
  input  logic [1:0] i_bp_mode,
  input  logic [7:0] i_bp_period,
  output logic       o_ready
);

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [7:0]  r_duty;
  logic [7:0]  w_duty_next;
  logic        w_ready_next;

  // Next LFSR/duty state and the ready value for the coming cycle.
  always_comb begin
    w_lfsr_next  = r_lfsr;
    w_duty_next  = 8'd0;
    w_ready_next = 1'b0;
    if (i_run_next) begin
      if (i_bp_mode == BP_LFSR) begin
        w_lfsr_next = lfsr_step(r_lfsr);
      end else begin
        w_lfsr_next = r_lfsr;
      end
      // The counter restarts at 0 on entry to RUN so the first run cycle is ready.
      if (i_run && (r_duty < i_bp_period)) begin
        w_duty_next = r_duty + 8'd1;
      end else begin
        w_duty_next = 8'd0;
      end
      case (i_bp_mode)
        BP_ALWAYS: w_ready_next = 1'b1;
        BP_LFSR:   w_ready_next = w_lfsr_next[0];
        BP_DUTY:   w_ready_next = (w_duty_next == 8'd0);
        BP_NEVER:  w_ready_next = 1'b0;
        default:   w_ready_next = 1'b0;
      endcase
    end else begin
      w_lfsr_next  = r_lfsr;
      w_duty_next  = 8'd0;
      w_ready_next = 1'b0;
    end
  end

  // Generator state and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr  <= LFSR_SEED;
      r_duty  <= 8'd0;
      o_ready <= 1'b0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_duty  <= w_duty_next;
      o_ready <= w_ready_next;
    end
  end

endmodule

// File: rtl/hs_stream_checker.sv
// Handshake stream checker: counts accepted beats and checks each word against
// an incrementing expectation. Define HS_CHK_PROTOCOL_EN for stall-protocol checking.
module hs_stream_checker
  import hs_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] start_val,
  input  logic [31:0]       len,
  input  logic [1:0]        bp_mode,
  input  logic [7:0]        bp_period,
  output logic [31:0]       beat_cnt,
  output logic [15:0]       err_cnt,
  output logic [DATA_W-1:0] first_err_data,
  output logic              err_flag,
  output logic              prot_err,
  output logic              done
);

  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_exp;
  logic              w_accept;
  logic              w_start_run;
  logic              w_last;

  assign w_accept    = valid_in & ready_out & (r_state == ST_RUN) & ~clear;
  assign w_start_run = start & ~clear & (r_state == ST_IDLE);
  assign w_last      = (len != 32'd0) && ((beat_cnt + 32'd1) == len);

  // Next-state logic; clear overrides everything else.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = start ? ST_RUN : ST_IDLE;
        ST_RUN:  w_state_next = (w_accept && w_last) ? ST_DONE : ST_RUN;
        ST_DONE: w_state_next = ST_DONE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // State register and done level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      done    <= (w_state_next == ST_DONE);
    end
  end

  hs_bp_gen #(
    .LFSR_SEED(LFSR_SEED)
  ) u_bp_gen (
    .clk        (clk),
    .rst        (rst),
    .i_run      (r_state == ST_RUN),
    .i_run_next (w_state_next == ST_RUN),
    .i_bp_mode  (bp_mode),
    .i_bp_period(bp_period),
    .o_ready    (ready_out)
  );

  // Beat counting, data check and resync of the expected word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp          <= {DATA_W{1'b0}};
      beat_cnt       <= 32'd0;
      err_cnt        <= 16'd0;
      err_flag       <= 1'b0;
      first_err_data <= {DATA_W{1'b0}};
    end else if (w_start_run) begin
      r_exp          <= start_val;
      beat_cnt       <= 32'd0;
      err_cnt        <= 16'd0;
      err_flag       <= 1'b0;
      first_err_data <= {DATA_W{1'b0}};
    end else if (w_accept) begin
      beat_cnt <= beat_cnt + 32'd1;
      r_exp    <= data_in + DATA_ONE;
      if (data_in != r_exp) begin
        if (err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
        if (!err_flag) begin
          first_err_data <= data_in;
        end
        err_flag <= 1'b1;
      end
    end
  end

`ifdef HS_CHK_PROTOCOL_EN
  logic              r_stalled;
  logic [DATA_W-1:0] r_stall_data;

  // A stalled offer must be held unchanged until it is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stalled    <= 1'b0;
      r_stall_data <= {DATA_W{1'b0}};
      prot_err     <= 1'b0;
    end else begin
      r_stalled    <= (r_state == ST_RUN) & valid_in & ~ready_out;
      r_stall_data <= data_in;
      if (w_start_run) begin
        prot_err <= 1'b0;
      end else if ((r_state == ST_RUN) && r_stalled &&
                   (!valid_in || (data_in != r_stall_data))) begin
        prot_err <= 1'b1;
      end
    end
  end
`else
  assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_stream_checker.sv
// Self-checking bench for hs_stream_checker: directed vector table, hand-written
// corner sequences and randomized runs against a behavioural stream model.
module tb_hs_stream_checker;

  localparam int DW = 16;

`ifdef HS_CHK_PROTOCOL_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          ready_out;
  logic          start;
  logic          clear;
  logic [DW-1:0] start_val;
  logic [31:0]   len;
  logic [1:0]    bp_mode;
  logic [7:0]    bp_period;
  logic [31:0]   beat_cnt;
  logic [15:0]   err_cnt;
  logic [DW-1:0] first_err_data;
  logic          err_flag;
  logic          prot_err;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hs_stream_checker #(.DATA_W(DW), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_out(ready_out), .start(start), .clear(clear), .start_val(start_val),
    .len(len), .bp_mode(bp_mode), .bp_period(bp_period), .beat_cnt(beat_cnt),
    .err_cnt(err_cnt), .first_err_data(first_err_data), .err_flag(err_flag),
    .prot_err(prot_err), .done(done)
  );

  // Behavioural model of the stream check: expected word, counts and first error.
  logic [31:0]   m_beat;
  logic [15:0]   m_err;
  logic [DW-1:0] m_first;
  logic [DW-1:0] m_exp;
  logic          m_flag;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_start(input logic [DW-1:0] sv);
    m_beat = 32'd0; m_err = 16'd0; m_first = '0; m_flag = 1'b0; m_exp = sv;
  endtask

  task automatic model_accept(input logic [DW-1:0] d);
    if (d != m_exp) begin
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      if (!m_flag) m_first = d;
      m_flag = 1'b1;
    end
    m_exp  = d + 16'd1;
    m_beat = m_beat + 32'd1;
  endtask

  task automatic start_run(input logic [DW-1:0] sv, input logic [31:0] l,
                           input logic [1:0] m, input logic [7:0] p);
    start_val = sv; len = l; bp_mode = m; bp_period = p;
    start = 1'b1;
    tick;
    start = 1'b0;
    model_start(sv);
  endtask

  task automatic do_clear;
    valid_in = 1'b0;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  // Offer one word and hold it until taken; returns at the negedge after the accept.
  task automatic send_word(input logic [DW-1:0] d);
    int waited;
    valid_in = 1'b1;
    data_in  = d;
    waited   = 0;
    while (!ready_out && waited < 200) begin
      tick;
      waited++;
    end
    if (!ready_out) begin
      check("send_timeout", 64'(waited), 64'd0);
    end else begin
      tick;
      model_accept(d);
    end
  endtask

  typedef struct {
    logic [DW-1:0]      sv;
    logic [31:0]        len;
    int                 n;
    logic [3:0][DW-1:0] d;
    logic [31:0]        e_beat;
    logic [15:0]        e_err;
    logic [DW-1:0]      e_first;
    logic               e_flag;
    logic               e_done;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cycles;
    int last_acc;
    int bad_space;
    int n_rdy;
    logic acc;
    logic [1:0] r_mode;
    logic [7:0] r_per;
    logic [31:0] r_len;
    logic [DW-1:0] r_sv;
    logic [DW-1:0] r_d;

    vecs[0] = '{16'h0000, 32'd4, 4, {16'h0006, 16'h0005, 16'h0001, 16'h0000},
                32'd4, 16'd1, 16'h0005, 1'b1, 1'b1};
    vecs[1] = '{16'hFFFE, 32'd3, 3, {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE},
                32'd3, 16'd0, 16'h0000, 1'b0, 1'b1};
    vecs[2] = '{16'h0100, 32'd4, 4, {16'h0400, 16'h0301, 16'h0300, 16'h0200},
                32'd4, 16'd3, 16'h0200, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 32'd0, 4, {16'h0008, 16'h0007, 16'h0006, 16'h0005},
                32'd4, 16'd0, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1; valid_in = 1'b0; data_in = '0; start = 1'b0; clear = 1'b0;
    start_val = '0; len = 32'd0; bp_mode = 2'd0; bp_period = 8'd0;
    tick; tick;
    check("rst_ready", ready_out, 1'b0);
    check("rst_beat", beat_cnt, 32'd0);
    check("rst_err", err_cnt, 16'd0);
    check("rst_done", done, 1'b0);
    check("rst_prot", prot_err, 1'b0);
    rst = 1'b0;
    tick;
    check("idle_ready", ready_out, 1'b0);

    // Directed vector table, always-ready.
    for (int i = 0; i < 4; i++) begin
      do_clear;
      start_run(vecs[i].sv, vecs[i].len, 2'd0, 8'd0);
      for (int k = 0; k < vecs[i].n; k++) send_word(vecs[i].d[k]);
      valid_in = 1'b0;
      check($sformatf("vec%0d_beat", i), beat_cnt, vecs[i].e_beat);
      check($sformatf("vec%0d_err", i), err_cnt, vecs[i].e_err);
      check($sformatf("vec%0d_first", i), first_err_data, vecs[i].e_first);
      check($sformatf("vec%0d_flag", i), err_flag, vecs[i].e_flag);
      check($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      check($sformatf("vec%0d_ready", i), ready_out, !vecs[i].e_done);
    end

    // Back-to-back run of 8: done first visible after the 8th accept.
    do_clear;
    start_run(16'h0010, 32'd8, 2'd0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      send_word(16'h0010 + 16'(i));
      if (i == 6) check("b2b_done_early", done, 1'b0);
    end
    valid_in = 1'b0;
    check("b2b_done", done, 1'b1);
    check("b2b_ready", ready_out, 1'b0);
    check("b2b_beat", beat_cnt, 32'd8);
    check("b2b_err", err_cnt, 16'd0);

    // Duty mode, period 3: one accept every 4 cycles.
    do_clear;
    start_run(16'h0040, 32'd4, 2'd2, 8'd3);
    valid_in = 1'b1; data_in = 16'h0040;
    cycles = 0; last_acc = -1; bad_space = 0;
    while (!done && cycles < 100) begin
      acc = ready_out;
      tick;
      cycles++;
      if (acc) begin
        if (last_acc >= 0 && (cycles - last_acc) != 4) bad_space++;
        last_acc = cycles;
        data_in = data_in + 16'd1;
      end
    end
    valid_in = 1'b0;
    check("duty_done", done, 1'b1);
    check("duty_latency_ok", 64'((cycles >= 13) && (cycles <= 16)), 64'd1);
    check("duty_spacing_bad", 64'(bad_space), 64'd0);
    check("duty_beat", beat_cnt, 32'd4);
    check("duty_err", err_cnt, 16'd0);

    // LFSR mode: ready must show both levels; every ready cycle with valid is a beat.
    do_clear;
    start_run(16'h0000, 32'd0, 2'd1, 8'd0);
    valid_in = 1'b1; data_in = 16'h0000; n_rdy = 0;
    for (int i = 0; i < 64; i++) begin
      acc = ready_out;
      tick;
      if (acc) begin
        n_rdy++;
        data_in = data_in + 16'd1;
      end
    end
    valid_in = 1'b0;
    check("lfsr_mixed", 64'((n_rdy > 0) && (n_rdy < 64)), 64'd1);
    check("lfsr_beat", beat_cnt, 32'(n_rdy));
    check("lfsr_err", err_cnt, 16'd0);

    // Protocol: stable stall is legal, data change while stalled is not.
    do_clear;
    start_run(16'h1234, 32'd4, 2'd3, 8'd0);
    valid_in = 1'b1; data_in = 16'h1234;
    tick; tick;
    check("prot_stable", prot_err, 1'b0);
    check("never_ready", ready_out, 1'b0);
    data_in = 16'h1235;
    tick;
    check("prot_change", prot_err, PROT_EN);
    check("never_beat", beat_cnt, 32'd0);

    // Clear beats a simultaneous start and accept.
    do_clear;
    start_run(16'h0000, 32'd5, 2'd0, 8'd0);
    send_word(16'h0000);
    data_in = 16'h0001;
    clear = 1'b1; start = 1'b1;
    tick;
    clear = 1'b0; start = 1'b0;
    check("clr_prio_beat", beat_cnt, 32'd1);
    check("clr_prio_ready", ready_out, 1'b0);
    tick;
    check("clr_prio_idle", ready_out, 1'b0);

    // Start is ignored while running.
    start_run(16'h0000, 32'd5, 2'd0, 8'd0);
    send_word(16'h0000);
    send_word(16'h0001);
    valid_in = 1'b0; start_val = 16'h0007; start = 1'b1;
    tick;
    start = 1'b0;
    check("start_in_run_beat", beat_cnt, 32'd2);
    check("start_in_run_ready", ready_out, 1'b1);

    // Reset mid-run after 3 beats, then a fresh run.
    do_clear;
    start_run(16'h0000, 32'd10, 2'd0, 8'd0);
    send_word(16'h0000); send_word(16'h0001); send_word(16'h0009);
    data_in = 16'h000A;
    rst = 1'b1;
    tick;
    check("mrst_beat", beat_cnt, 32'd0);
    check("mrst_err", err_cnt, 16'd0);
    check("mrst_first", first_err_data, 16'd0);
    check("mrst_flag", err_flag, 1'b0);
    check("mrst_ready", ready_out, 1'b0);
    check("mrst_done", done, 1'b0);
    rst = 1'b0; valid_in = 1'b0;
    tick;
    start_run(16'h0000, 32'd2, 2'd0, 8'd0);
    send_word(16'h0000); send_word(16'h0001);
    valid_in = 1'b0;
    check("mrst_rerun_beat", beat_cnt, 32'd2);
    check("mrst_rerun_done", done, 1'b1);

    // Randomized runs against the model.
    for (int r = 0; r < 30; r++) begin
      do_clear;
      r_mode = 2'($urandom_range(0, 2));
      r_per  = 8'($urandom_range(0, 3));
      r_len  = 32'($urandom_range(1, 20));
      r_sv   = (r % 4 == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
      start_run(r_sv, r_len, r_mode, r_per);
      for (int b = 0; b < int'(r_len); b++) begin
        valid_in = 1'b0;
        for (int g = $urandom_range(0, 2); g > 0; g--) tick;
        r_d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : m_exp;
        send_word(r_d);
      end
      valid_in = 1'b0;
      check($sformatf("rnd%0d_beat", r), beat_cnt, m_beat);
      check($sformatf("rnd%0d_err", r), err_cnt, m_err);
      check($sformatf("rnd%0d_first", r), first_err_data, m_first);
      check($sformatf("rnd%0d_flag", r), err_flag, m_flag);
      check($sformatf("rnd%0d_done", r), done, 1'b1);
      check($sformatf("rnd%0d_ready", r), ready_out, 1'b0);
      check($sformatf("rnd%0d_prot", r), prot_err, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
